c_wf_alloc_ctrl: RTL and testbench
==================================

// Module: c_wf_alloc_ctrl
// PURPOSE
//  Switch-allocation control stage that wraps the wavefront allocator.
//  - Upstream: builds the input x output request matrix from per-input head flits.
//  - Downstream: consumes the grant matrix, pops flits and registers one-hot crossbar selects.
//  - Locks the granted input->output connection for the rest of a multi-flit packet.
//  - Locked inputs bypass the allocator until their tail flit is popped.
// PARAMETERS
//  num_ports  8  number of switch input ports and output ports (square crossbar)
// PORTS
//  clk           input   1      clock
//  reset         input   1      synchronous, active-low reset
//  active        input   1      register enable; all state holds while 0
//  in_valid      input   N      input i has a flit at its head
//  in_head       input   N      head-of-packet flag of that flit
//  in_tail       input   N      tail-of-packet flag (head&tail = single-flit packet)
//  in_dest       input   N*N    per input, one-hot destination output; [i*N+o]
//  out_ready     input   N      output o can accept a flit this cycle
//  alloc_req     output  N*N    request matrix to allocator; [i*N+o], row = input
//  alloc_gnt     input   N*N    grant matrix from allocator, same layout as alloc_req
//  alloc_update  output  1      allocator priority-update strobe
//  in_pop        output  N      flit at input i is consumed this cycle
//  xbar_sel      output  N*N    registered, per output one-hot input select; [o*N+i]
//  out_valid     output  N      registered, output o carries a flit this cycle
//  out_busy      output  N      registered, output o is locked by a packet in flight
// BEHAVIOUR
//  Reset (reset==0 at clk edge):
//   - every input FSM goes to IDLE; all locks clear.
//   - xbar_sel, out_valid and out_busy are 0.
//  Combinational outputs:
//   - alloc_req, in_pop and alloc_update are 0 while reset==0 or active==0.
//  Per-input FSM states: IDLE, LOCKED (holds lock_dest, one-hot N).
//  IDLE request rule:
//   - alloc_req[i*N+o] = in_valid[i] & in_head[i] & in_dest[i*N+o] & out_ready[o] & ~out_busy[o].
//  Grant use:
//   - gnt_eff = alloc_gnt & alloc_req; grants without a matching request are ignored.
//   - any bit of row i of gnt_eff -> in_pop[i]=1 in the same cycle.
//   - if ~in_tail[i]: next state LOCKED, lock_dest=o, out_busy[o]=1 from next cycle.
//   - if in_tail[i] (single-flit packet): stay IDLE, no lock.
//  alloc_update = |gnt_eff, same cycle.
//  LOCKED:
//   - input raises no allocator request.
//   - in_pop[i] = in_valid[i] & out_ready[lock_dest].
//   - popped tail: next state IDLE; out_busy[lock_dest] clears next cycle.
//   - a head flit seen while LOCKED is a protocol error: assertion fires, flit is not popped.
//  IDLE, non-head valid flit: not popped; assertion fires.
//  Crossbar stage:
//   - at each active edge, out_valid[o] <= OR over i of (in_pop[i] & flit routed to o).
//   - route is in_dest in IDLE, lock_dest in LOCKED.
//   - xbar_sel[o*N+i] <= in_pop[i] & routed to o.
//   - latency from in_pop to out_valid/xbar_sel is 1 cycle.
//  Lock release:
//   - no same-cycle reuse: an output freed by a tail pop can be requested from the next cycle.
//   - an input returning to IDLE presents its next head from the next cycle.
//  Conflicts:
//   - at most one in_pop per output per cycle.
//   - guaranteed because busy outputs are never requested and the allocator grants one per column.
//   - an assertion checks for one-hot columns in gnt_eff and at most one bit per row.
//  Reset mid-packet:
//   - locks drop; upstream buffers are flushed by the same reset.
//   - stray body flits seen afterwards are handled per the IDLE non-head rule.
//  active==0: all state holds; no requests or pops are generated.
// STRUCTURE
//  Shared package c_wf_alloc_pkg:
//   - input-state enum {IDLE, LOCKED}.
//   - index helper functions for the [row*N+col] layout.
//  Sub-module c_wf_alloc_ctrl_ip: one per input (generate loop).
//   - holds the FSM and lock_dest.
//   - produces the request row, in_pop and the route vector.
//  Top level:
//   - OR-reduces lock vectors into out_busy.
//   - transposes the route & pop vectors into the xbar_sel/out_valid registers.
// TESTING (N=4)
//  1. Single flits: in0 and in1 both head+tail to out2, allocator grants in1
//     -> in_pop=0010, alloc_update=1; next cycle out_valid=0100, xbar_sel[2*4+1]=1.
//  2. 3-flit packet in0->out3, out_ready=1111
//     -> pops on 3 consecutive cycles; alloc_req row 0 only in cycle 0;
//        out_busy[3]=1 for 2 cycles; in2 head->out3 requests only after the tail pop.
//  3. Backpressure: out_ready[3]=0 while in0 LOCKED
//     -> in_pop[0]=0, state held; pop resumes the cycle out_ready[3] returns to 1.
//  4. Reset (reset=0) asserted mid-packet
//     -> next cycle out_busy=0, out_valid=0, FSM IDLE; a following body flit is not popped.
//  5. Spurious alloc_gnt bit with no matching request -> no pop, alloc_update=0.
//  6. Busy output with in_dest->out1 head, out_busy[1]=1
//     -> alloc_req[*][1]=0 and no request from that input for that output.

Source files
------------

// File: rtl/c_wf_alloc_pkg.sv
// Shared types and index helpers for the wavefront switch-allocation
// control stage.
package c_wf_alloc_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } ip_state_e;

    // Request/grant layout: row = input, col = output.
    function automatic int unsigned rc_idx(
        input int unsigned row,
        input int unsigned col,
        input int unsigned n
    );
        return row * n + col;
    endfunction

    // Crossbar select layout: row = output, col = input.
    function automatic int unsigned sel_idx(
        input int unsigned out_p,
        input int unsigned in_p,
        input int unsigned n
    );
        return out_p * n + in_p;
    endfunction

endpackage

// File: rtl/c_wf_alloc_ctrl_ip.sv
// Per-input control: request row, pop, route and packet lock
// for one switch input.
module c_wf_alloc_ctrl_ip
    import c_wf_alloc_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         active,
    input  logic         in_valid,
    input  logic         in_head,
    input  logic         in_tail,
    input  logic [N-1:0] in_dest,
    input  logic [N-1:0] out_ready,
    input  logic [N-1:0] out_busy,
    input  logic [N-1:0] alloc_gnt,
    output logic [N-1:0] alloc_req,
    output logic         in_pop,
    output logic [N-1:0] route,
    output logic [N-1:0] lock_dest
);

    ip_state_e    r_state;
    logic [N-1:0] r_lock_dest;
    logic [N-1:0] w_gnt_eff;
    logic         w_en;
    logic         w_pop_idle;
    logic         w_pop_lock;

    assign w_en = reset & active;

    always_comb begin
        alloc_req = '0;
        if (w_en && r_state == IDLE && in_valid && in_head)
            alloc_req = in_dest & out_ready & ~out_busy;
    end

    // Grants that do not match a request are dropped here.
    assign w_gnt_eff  = alloc_gnt & alloc_req;
    assign w_pop_idle = |w_gnt_eff;
    assign w_pop_lock = w_en && r_state == LOCKED && in_valid
                        && !in_head && |(r_lock_dest & out_ready);
    assign in_pop     = w_pop_idle | w_pop_lock;
    assign route      = (r_state == LOCKED) ? r_lock_dest : in_dest;
    assign lock_dest  = r_lock_dest;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_lock_dest <= '0;
        end else if (active) begin
            unique case (r_state)
                IDLE: begin
                    if (w_pop_idle && !in_tail) begin
                        r_state     <= LOCKED;
                        r_lock_dest <= w_gnt_eff;
                    end
                end
                LOCKED: begin
                    if (w_pop_lock && in_tail) begin
                        r_state     <= IDLE;
                        r_lock_dest <= '0;
                    end
                end
            endcase
        end
    end

    // Protocol checks: these flits are left in place, never popped.
    always_ff @(posedge clk) begin
        if (w_en && in_valid) begin
            if (r_state == IDLE)
                a_idle_head : assert (in_head)
                    else $warning("protocol: body flit at idle input");
            else
                a_lock_body : assert (!in_head)
                    else $warning("protocol: head flit at locked input");
        end
    end

endmodule

// File: rtl/c_wf_alloc_ctrl.sv
// Switch-allocation control stage around the wavefront allocator:
// request build, grant use, packet locks and crossbar select registers.
module c_wf_alloc_ctrl
    import c_wf_alloc_pkg::*;
#(
    parameter int num_ports = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           active,
    input  logic [num_ports-1:0]           in_valid,
    input  logic [num_ports-1:0]           in_head,
    input  logic [num_ports-1:0]           in_tail,
    input  logic [num_ports*num_ports-1:0] in_dest,
    input  logic [num_ports-1:0]           out_ready,
    output logic [num_ports*num_ports-1:0] alloc_req,
    input  logic [num_ports*num_ports-1:0] alloc_gnt,
    output logic                           alloc_update,
    output logic [num_ports-1:0]           in_pop,
    output logic [num_ports*num_ports-1:0] xbar_sel,
    output logic [num_ports-1:0]           out_valid,
    output logic [num_ports-1:0]           out_busy
);

    localparam int N = num_ports;

    logic [N-1:0]   w_route [N];
    logic [N-1:0]   w_lock  [N];
    logic [N-1:0]   w_busy;
    logic [N*N-1:0] w_gnt_eff;
    logic [N-1:0]   w_gnt_col [N];
    logic [N*N-1:0] w_sel_nxt;
    logic [N-1:0]   w_ov_nxt;
    logic [N*N-1:0] r_xbar_sel;
    logic [N-1:0]   r_out_valid;

    for (genvar gi = 0; gi < N; gi++) begin : g_ip
        c_wf_alloc_ctrl_ip #(
            .N (N)
        ) u_ip (
            .clk       (clk),
            .reset     (reset),
            .active    (active),
            .in_valid  (in_valid[gi]),
            .in_head   (in_head[gi]),
            .in_tail   (in_tail[gi]),
            .in_dest   (in_dest[gi*N +: N]),
            .out_ready (out_ready),
            .out_busy  (w_busy),
            .alloc_gnt (alloc_gnt[gi*N +: N]),
            .alloc_req (alloc_req[gi*N +: N]),
            .in_pop    (in_pop[gi]),
            .route     (w_route[gi]),
            .lock_dest (w_lock[gi])
        );
    end

    // Lock vectors are registered, so out_busy is a register OR.
    always_comb begin
        w_busy = '0;
        for (int i = 0; i < N; i++)
            w_busy = w_busy | w_lock[i];
    end

    assign out_busy     = w_busy;
    assign w_gnt_eff    = alloc_gnt & alloc_req;
    assign alloc_update = |w_gnt_eff;

    always_comb begin
        w_sel_nxt = '0;
        w_ov_nxt  = '0;
        for (int o = 0; o < N; o++) begin
            w_gnt_col[o] = '0;
            for (int i = 0; i < N; i++) begin
                w_sel_nxt[sel_idx(o, i, N)] = in_pop[i] & w_route[i][o];
                w_gnt_col[o][i] = w_gnt_eff[rc_idx(i, o, N)];
            end
            w_ov_nxt[o] = |w_sel_nxt[o*N +: N];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_xbar_sel  <= '0;
            r_out_valid <= '0;
        end else if (active) begin
            r_xbar_sel  <= w_sel_nxt;
            r_out_valid <= w_ov_nxt;
        end
    end

    assign xbar_sel  = r_xbar_sel;
    assign out_valid = r_out_valid;

    always_ff @(posedge clk) begin
        if (reset && active) begin
            for (int k = 0; k < N; k++) begin
                a_col : assert ($onehot0(w_gnt_col[k]))
                    else $error("two grants on one output");
                a_row : assert ($onehot0(w_gnt_eff[k*N +: N]))
                    else $error("two grants on one input");
            end
        end
    end

endmodule

// File: tb/tb_c_wf_alloc_ctrl.sv
// Self-checking bench for c_wf_alloc_ctrl (4 ports): vector table
// with a scoreboard queue for the registered crossbar outputs.
module tb_c_wf_alloc_ctrl;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        active;
    logic [3:0]  in_valid;
    logic [3:0]  in_head;
    logic [3:0]  in_tail;
    logic [15:0] in_dest;
    logic [3:0]  out_ready;
    logic [15:0] alloc_req;
    logic [15:0] alloc_gnt;
    logic        alloc_update;
    logic [3:0]  in_pop;
    logic [15:0] xbar_sel;
    logic [3:0]  out_valid;
    logic [3:0]  out_busy;

    always #5 clk = ~clk;

    c_wf_alloc_ctrl #(
        .num_ports (N)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .active       (active),
        .in_valid     (in_valid),
        .in_head      (in_head),
        .in_tail      (in_tail),
        .in_dest      (in_dest),
        .out_ready    (out_ready),
        .alloc_req    (alloc_req),
        .alloc_gnt    (alloc_gnt),
        .alloc_update (alloc_update),
        .in_pop       (in_pop),
        .xbar_sel     (xbar_sel),
        .out_valid    (out_valid),
        .out_busy     (out_busy)
    );

    typedef struct {
        logic        rst;
        logic        act;
        logic [3:0]  vld;
        logic [3:0]  hd;
        logic [3:0]  tl;
        logic [15:0] dst;
        logic [3:0]  rdy;
        logic [15:0] gnt;
        logic [15:0] req;
        logic [3:0]  pop;
        logic        upd;
        logic [3:0]  ov;
        logic [15:0] xs;
        logic [3:0]  bsy;
    } vec_t;

    typedef struct packed {
        logic [3:0]  ov;
        logic [15:0] xs;
        logic [3:0]  bsy;
    } exp_t;

    exp_t sbq[$];
    vec_t tv[20];
    int   n_chk  = 0;
    int   n_pass = 0;

    // One-hot bit for input i routed to output o, [i*4+o].
    function automatic logic [15:0] d(input int i, input int o);
        logic [15:0] v;
        v = '0;
        v[i*4+o] = 1'b1;
        return v;
    endfunction

    function automatic vec_t mk(
        input logic rst, input logic act,
        input logic [3:0] vld, input logic [3:0] hd,
        input logic [3:0] tl, input logic [15:0] dst,
        input logic [3:0] rdy, input logic [15:0] gnt,
        input logic [15:0] req, input logic [3:0] pop,
        input logic upd, input logic [3:0] ov,
        input logic [15:0] xs, input logic [3:0] bsy
    );
        vec_t v;
        v.rst = rst; v.act = act; v.vld = vld; v.hd = hd;
        v.tl = tl; v.dst = dst; v.rdy = rdy; v.gnt = gnt;
        v.req = req; v.pop = pop; v.upd = upd;
        v.ov = ov; v.xs = xs; v.bsy = bsy;
        return v;
    endfunction

    task automatic chk(
        input string nm,
        input logic [31:0] act_v,
        input logic [31:0] exp_v
    );
        n_chk++;
        if (act_v === exp_v)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", nm, act_v, exp_v);
    endtask

    task automatic apply(input vec_t v, input string tag);
        exp_t e;
        reset     = v.rst;
        active    = v.act;
        in_valid  = v.vld;
        in_head   = v.hd;
        in_tail   = v.tl;
        in_dest   = v.dst;
        out_ready = v.rdy;
        alloc_gnt = v.gnt;
        sbq.push_back({v.ov, v.xs, v.bsy});
        #4;
        chk({tag, " req"}, 32'(alloc_req), 32'(v.req));
        chk({tag, " pop"}, 32'(in_pop), 32'(v.pop));
        chk({tag, " upd"}, 32'(alloc_update), 32'(v.upd));
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk({tag, " out_valid"}, 32'(out_valid), 32'(e.ov));
        chk({tag, " xbar_sel"}, 32'(xbar_sel), 32'(e.xs));
        chk({tag, " out_busy"}, 32'(out_busy), 32'(e.bsy));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tv[0]  = mk(0, 1, 4'hF, 4'hF, 4'hF,
                    d(0,0) | d(1,1) | d(2,2) | d(3,3), 4'hF,
                    d(0,0) | d(1,1) | d(2,2) | d(3,3),
                    16'h0, 4'h0, 0, 4'h0, 16'h0, 4'h0);
        tv[1]  = mk(1, 1, 4'h3, 4'h3, 4'h3, d(0,2) | d(1,2), 4'hF,
                    d(1,2), 16'h0044, 4'h2, 1, 4'h4, 16'h0200, 4'h0);
        tv[2]  = mk(1, 1, 4'h0, 4'h0, 4'h0, 16'h0, 4'hF, 16'h0,
                    16'h0, 4'h0, 0, 4'h0, 16'h0, 4'h0);
        tv[3]  = mk(1, 1, 4'h5, 4'h5, 4'h0, d(0,3) | d(2,3), 4'hF,
                    d(0,3), 16'h0808, 4'h1, 1, 4'h8, 16'h1000, 4'h8);
        tv[4]  = mk(1, 1, 4'h5, 4'h4, 4'h0, d(0,3) | d(2,3), 4'hF,
                    16'h0, 16'h0, 4'h1, 0, 4'h8, 16'h1000, 4'h8);
        tv[5]  = mk(1, 1, 4'h5, 4'h4, 4'h0, d(0,3) | d(2,3), 4'h7,
                    16'h0, 16'h0, 4'h0, 0, 4'h0, 16'h0, 4'h8);
        tv[6]  = mk(1, 1, 4'h5, 4'h4, 4'h1, d(0,3) | d(2,3), 4'hF,
                    16'h0, 16'h0, 4'h1, 0, 4'h8, 16'h1000, 4'h0);
        tv[7]  = mk(1, 1, 4'h4, 4'h4, 4'h4, d(2,3), 4'hF,
                    d(2,3), 16'h0800, 4'h4, 1, 4'h8, 16'h4000, 4'h0);
        tv[8]  = mk(1, 1, 4'h0, 4'h0, 4'h0, 16'h0, 4'hF,
                    d(1,0) | d(3,2), 16'h0, 4'h0, 0, 4'h0, 16'h0, 4'h0);
        tv[9]  = mk(1, 1, 4'h1, 4'h1, 4'h1, d(0,1), 4'hF,
                    d(0,2), 16'h0002, 4'h0, 0, 4'h0, 16'h0, 4'h0);
        tv[10] = mk(1, 1, 4'h8, 4'h8, 4'h0, d(3,1), 4'hF,
                    d(3,1), 16'h2000, 4'h8, 1, 4'h2, 16'h0080, 4'h2);
        tv[11] = mk(1, 1, 4'hB, 4'h3, 4'h2,
                    d(3,1) | d(0,1) | d(1,0), 4'hF, d(1,0) | d(0,1),
                    16'h0010, 4'hA, 1, 4'h3, 16'h0082, 4'h2);
        tv[12] = mk(1, 1, 4'h9, 4'h1, 4'h8, d(3,1) | d(0,1), 4'hF,
                    16'h0, 16'h0, 4'h8, 0, 4'h2, 16'h0080, 4'h0);
        tv[13] = mk(1, 1, 4'h1, 4'h1, 4'h1, d(0,1), 4'hF,
                    d(0,1), 16'h0002, 4'h1, 1, 4'h2, 16'h0010, 4'h0);
        tv[14] = mk(1, 1, 4'h4, 4'h4, 4'h0, d(2,0), 4'hF,
                    d(2,0), 16'h0100, 4'h4, 1, 4'h1, 16'h0004, 4'h1);
        tv[15] = mk(1, 0, 4'h4, 4'h0, 4'h0, d(2,0), 4'hF,
                    16'h0, 16'h0, 4'h0, 0, 4'h1, 16'h0004, 4'h1);
        tv[16] = mk(1, 1, 4'h4, 4'h0, 4'h4, d(2,0), 4'hF,
                    16'h0, 16'h0, 4'h4, 0, 4'h1, 16'h0004, 4'h0);
        tv[17] = mk(1, 1, 4'h2, 4'h2, 4'h0, d(1,2), 4'hF,
                    d(1,2), 16'h0040, 4'h2, 1, 4'h4, 16'h0200, 4'h4);
        tv[18] = mk(0, 1, 4'h2, 4'h0, 4'h0, d(1,2), 4'hF,
                    16'h0, 16'h0, 4'h0, 0, 4'h0, 16'h0, 4'h0);
        tv[19] = mk(1, 1, 4'h2, 4'h0, 4'h0, d(1,2), 4'hF,
                    d(1,2), 16'h0, 4'h0, 0, 4'h0, 16'h0, 4'h0);

        reset     = 1'b0;
        active    = 1'b1;
        in_valid  = '0;
        in_head   = '0;
        in_tail   = '0;
        in_dest   = '0;
        out_ready = '0;
        alloc_gnt = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", 32'(out_valid), 32'h0);
        chk("reset xbar_sel", 32'(xbar_sel), 32'h0);
        chk("reset out_busy", 32'(out_busy), 32'h0);

        for (int k = 0; k < 20; k++)
            apply(tv[k], $sformatf("v%0d", k));

        // Head flit at a locked input must wait for the tail.
        apply(mk(1, 1, 4'h1, 4'h1, 4'h0, d(0,0), 4'hF, d(0,0),
                 16'h0001, 4'h1, 1, 4'h1, 16'h0001, 4'h1), "lk_a");
        apply(mk(1, 1, 4'h1, 4'h1, 4'h0, d(0,0), 4'hF, d(0,0),
                 16'h0, 4'h0, 0, 4'h0, 16'h0, 4'h1), "lk_b");
        apply(mk(1, 1, 4'h1, 4'h0, 4'h1, d(0,0), 4'hF, 16'h0,
                 16'h0, 4'h1, 0, 4'h1, 16'h0001, 4'h0), "lk_c");
        apply(mk(1, 1, 4'h1, 4'h1, 4'h1, d(0,0), 4'hF, d(0,0),
                 16'h0001, 4'h1, 1, 4'h1, 16'h0001, 4'h0), "lk_d");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
